nbj_correct_queue: RTL and testbench
====================================

NBJ_CORRECT_QUEUE -- requirements
Module: nbj_correct_queue

Interface
REQ-001 Parameter NUM_CH, default 2, number of correction source channels (1..8).
REQ-002 Parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-003 Parameter PC_W, default 32, corrected-PC width.
REQ-004 Parameter IDX_W, default 3, PC-index width; entry width E = PC_W+IDX_W+1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 i_valid  input  NUM_CH  per-channel correction request.
REQ-008 i_data  input  NUM_CH*E  channel k occupies bits [k*E +: E]; within an entry: [PC_W-1:0] corrected PC, [PC_W +: IDX_W] PC index, [E-1] type.
REQ-009 o_ready  output  NUM_CH  combinational per-channel accept; transfer on channel k when i_valid[k] and o_ready[k].
REQ-010 i_flush  input  1  discard all queued and in-flight corrections.
REQ-011 o_valid  output  1  head entry available.
REQ-012 i_ready  input  1  consumer accepts head; pop when o_valid and i_ready.
REQ-013 o_type  output  1  head entry type bit.
REQ-014 o_correctPcIndex  output  IDX_W  head entry PC index.
REQ-015 o_correctPc  output  PC_W  head entry corrected PC.
REQ-016 o_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Queue SHALL accept at most one channel per cycle, chosen by round-robin arbitration among asserted i_valid bits.
REQ-018 Arbiter SHALL grant the first requesting channel at or above rr_ptr (wrapping modulo NUM_CH); after a transfer, rr_ptr SHALL become granted+1 mod NUM_CH; rr_ptr SHALL NOT change without a transfer.
REQ-019 o_ready[k] SHALL be 1 only for the granted channel, and only when (o_count < DEPTH or a pop occurs this cycle) and i_flush is 0.
REQ-020 Accepted entry SHALL be written at the tail; o_valid SHALL reflect it the next cycle (push-to-visible latency 1 cycle).
REQ-021 o_valid SHALL equal (o_count != 0); o_type/o_correctPcIndex/o_correctPc SHALL show the head entry and hold stable while o_valid and not i_ready.
REQ-022 When o_valid is 0, data outputs SHALL hold the last popped values (zero after reset).
REQ-023 Simultaneous push and pop SHALL leave o_count unchanged; legal when full.
REQ-024 Head and tail pointers SHALL wrap modulo DEPTH; entries SHALL emerge in acceptance order.
REQ-025 i_flush SHALL, next cycle, make o_count 0 and o_valid 0, reset pointers, and reset rr_ptr to 0; a pop in the flush cycle SHALL still count as consumed by the consumer but SHALL not alter post-flush state.
REQ-026 i_flush SHALL override any push in the same cycle (o_ready all 0).

Reset
REQ-027 While rst is 1 at a clock edge: o_count 0, o_valid 0, o_type 0, o_correctPcIndex 0, o_correctPc 0, rr_ptr 0, pointers 0; o_ready all 0 while rst is 1.
REQ-028 Reset mid-operation SHALL discard all entries; storage array contents need not be cleared.

Structure
REQ-029 Shared package nbj_pkg SHALL hold the entry-field offsets/widths and the entry record type used by all nbj-path blocks.
REQ-030 Arbitration SHALL be a sub-module nbj_rr_arbiter (request vector in, one-hot grant and advance input, rr_ptr internal).

Verification
REQ-031 Single push ch0 PC=0x0000_1000, idx=5, type=1, i_ready=1 -> next cycle o_valid=1, o_correctPc=0x1000, o_correctPcIndex=5, o_type=1; following cycle o_count=0.
REQ-032 Both channels valid every cycle, i_ready=0, DEPTH=4 -> grants alternate ch0,ch1,ch0,ch1; o_count reaches 4; o_ready=00 thereafter.
REQ-033 Full queue, i_ready=1, ch1 valid -> push and pop same cycle, o_count stays 4, order preserved across pointer wrap.
REQ-034 o_count=3, i_flush=1 with ch0 valid -> o_ready=00; next cycle o_count=0, o_valid=0, next grant from ch0.
REQ-035 rst asserted with o_count=2 -> next cycle all outputs zero; first post-reset push appears after 1 cycle.

Source files
------------

// File: rtl/nbj_pkg.sv
// Shared definitions for the branch-correction (nbj) path: entry layout and record type.
// An entry is {type, pc_index, corrected_pc}, with the PC in the LSBs.
package nbj_pkg;
   localparam int NBJ_PC_W  = 32;
   localparam int NBJ_IDX_W = 3;

   typedef struct packed {
      logic                 typ;
      logic [NBJ_IDX_W-1:0] idx;
      logic [NBJ_PC_W-1:0]  pc;
   } nbj_entry_t;

   function automatic int nbj_idx_lsb(input int pc_w);
      return pc_w;
   endfunction

   function automatic int nbj_type_bit(input int pc_w, input int idx_w);
      return pc_w + idx_w;
   endfunction
endpackage

// File: rtl/nbj_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, wrapping.
// The pointer moves past the granted channel only when the caller reports a transfer.
module nbj_rr_arbiter #(
   parameter int NUM_CH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic [NUM_CH-1:0] i_req,
   input  logic              i_advance,
   output logic [NUM_CH-1:0] o_grant
);
   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_gidx;
   logic [PW:0]   w_pos;
   logic [PW:0]   w_nsum;
   logic [PW-1:0] w_next;
   logic          w_found;

   // Scan offsets 0..NUM_CH-1 from the pointer; first hit wins.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = r_ptr;
      w_pos   = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         w_pos = {1'b0, r_ptr} + (PW+1)'(j);
         if (w_pos >= (PW+1)'(NUM_CH)) w_pos = w_pos - (PW+1)'(NUM_CH);
         for (int k = 0; k < NUM_CH; k++) begin
            if (!w_found && i_req[k] && (w_pos == (PW+1)'(k))) begin
               w_found = 1'b1;
               w_gidx  = PW'(k);
            end
         end
      end
   end

   always_comb begin
      o_grant = '0;
      for (int k = 0; k < NUM_CH; k++)
         o_grant[k] = w_found && (w_gidx == PW'(k));
   end

   assign w_nsum = {1'b0, w_gidx} + (PW+1)'(1);
   assign w_next = (w_nsum >= (PW+1)'(NUM_CH)) ? '0 : w_nsum[PW-1:0];

   always_ff @(posedge clk) begin
      if (rst || i_clear)             r_ptr <= '0;
      else if (i_advance && w_found)  r_ptr <= w_next;
   end
endmodule

// File: rtl/nbj_correct_queue.sv
// Multi-channel correction queue: one round-robin-selected push per cycle into a
// DEPTH-entry FIFO; flush drops everything and restarts arbitration at channel 0.
module nbj_correct_queue
   import nbj_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 4,
   parameter int PC_W   = NBJ_PC_W,
   parameter int IDX_W  = NBJ_IDX_W
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CH-1:0]                i_valid,
   input  logic [NUM_CH*(PC_W+IDX_W+1)-1:0] i_data,
   output logic [NUM_CH-1:0]                o_ready,
   input  logic                             i_flush,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic                             o_type,
   output logic [IDX_W-1:0]                 o_correctPcIndex,
   output logic [PC_W-1:0]                  o_correctPc,
   output logic [$clog2(DEPTH):0]           o_count
);
   localparam int E       = PC_W + IDX_W + 1;
   localparam int AW      = $clog2(DEPTH);
   localparam int CW      = AW + 1;
   localparam int IDX_LSB = nbj_idx_lsb(PC_W);
   localparam int TYP_BIT = nbj_type_bit(PC_W, IDX_W);

   logic [E-1:0]      r_mem [DEPTH];
   logic [AW-1:0]     r_head;
   logic [AW-1:0]     r_tail;
   logic [CW-1:0]     r_count;
   logic [E-1:0]      r_last;

   logic [NUM_CH-1:0] w_grant;
   logic [E-1:0]      w_wdata;
   logic [E-1:0]      w_out;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_can_push;

   nbj_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (i_flush),
      .i_req     (i_valid),
      .i_advance (w_push),
      .o_grant   (w_grant)
   );

   assign o_valid    = (r_count != '0);
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_pop      = o_valid && i_ready;
   // A pop in the same cycle frees the slot, so a full queue can still accept.
   assign w_can_push = !rst && !i_flush && (!w_full || w_pop);
   assign o_ready    = w_grant & {NUM_CH{w_can_push}};
   assign w_push     = |(i_valid & o_ready);

   always_comb begin
      w_wdata = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (w_grant[k]) w_wdata = w_wdata | i_data[k*E +: E];
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_tail] <= w_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_last  <= '0;
      end else begin
         // The consumer still takes the head in a flush cycle, so it becomes the held value.
         if (w_pop) r_last <= r_mem[r_head];
         if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign w_out            = o_valid ? r_mem[r_head] : r_last;
   assign o_correctPc      = w_out[PC_W-1:0];
   assign o_correctPcIndex = w_out[IDX_LSB +: IDX_W];
   assign o_type           = w_out[TYP_BIT];
   assign o_count          = r_count;
endmodule

// File: tb/tb_nbj_correct_queue.sv
// Randomized + directed bench for nbj_correct_queue against a queue-based reference model.
module tb_nbj_correct_queue;
   import nbj_pkg::*;

   localparam int NUM_CH = 2;
   localparam int DEPTH  = 4;
   localparam int E      = NBJ_PC_W + NBJ_IDX_W + 1;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NUM_CH-1:0]       i_valid = '0;
   logic [NUM_CH*E-1:0]     i_data = '0;
   logic [NUM_CH-1:0]       o_ready;
   logic                    i_flush = 1'b0;
   logic                    o_valid;
   logic                    i_ready = 1'b0;
   logic                    o_type;
   logic [NBJ_IDX_W-1:0]    o_correctPcIndex;
   logic [NBJ_PC_W-1:0]     o_correctPc;
   logic [$clog2(DEPTH):0]  o_count;

   nbj_correct_queue #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .PC_W(NBJ_PC_W), .IDX_W(NBJ_IDX_W)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
      .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_type(o_type),
      .o_correctPcIndex(o_correctPcIndex), .o_correctPc(o_correctPc), .o_count(o_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   nbj_entry_t mq[$];
   nbj_entry_t last;
   int         rr = 0;
   bit         inited = 0;

   // values observed in the most recent cycle
   logic [NUM_CH-1:0] cap_ready;
   logic [63:0]       cap_cnt, cap_vld, cap_pc, cap_idx, cap_typ;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [E-1:0] mk(input logic t, input logic [NBJ_IDX_W-1:0] idx,
                                       input logic [NBJ_PC_W-1:0] pc);
      return {t, idx, pc};
   endfunction

   function automatic logic [NUM_CH*E-1:0] rnd_data();
      logic [NUM_CH*E-1:0] d;
      for (int k = 0; k < NUM_CH; k++) d[k*E +: E] = E'({$urandom(), $urandom()});
      return d;
   endfunction

   task automatic cyc(input logic r, input logic fl, input logic rdy,
                      input logic [NUM_CH-1:0] v, input logic [NUM_CH*E-1:0] d);
      int         g;
      int         sz;
      logic [NUM_CH-1:0] exp_rdy;
      nbj_entry_t hd;
      @(negedge clk);
      rst = r; i_flush = fl; i_ready = rdy; i_valid = v; i_data = d;
      #1;
      cap_ready = o_ready; cap_cnt = 64'(o_count); cap_vld = 64'(o_valid);
      cap_pc = 64'(o_correctPc); cap_idx = 64'(o_correctPcIndex); cap_typ = 64'(o_type);

      sz = mq.size();
      hd = (sz != 0) ? mq[0] : last;
      g = -1;
      for (int j = 0; j < NUM_CH; j++) begin
         int k;
         k = (rr + j) % NUM_CH;
         if (g < 0 && v[k]) g = k;
      end
      exp_rdy = '0;
      if (!r && !fl && g >= 0 && (sz < DEPTH || (sz > 0 && rdy))) exp_rdy[g] = 1'b1;

      if (inited) begin
         chk("count", cap_cnt, 64'(sz));
         chk("valid", cap_vld, 64'(sz != 0));
         chk("pc",    cap_pc,  64'(hd.pc));
         chk("idx",   cap_idx, 64'(hd.idx));
         chk("type",  cap_typ, 64'(hd.typ));
      end
      if (inited || r) chk("ready", 64'(cap_ready), 64'(exp_rdy));

      if (r) begin
         mq.delete(); rr = 0; last = '0; inited = 1;
      end else if (inited) begin
         if (sz != 0 && rdy) last = mq.pop_front();
         if (fl) begin
            mq.delete(); rr = 0;
         end else if (exp_rdy != '0) begin
            mq.push_back(nbj_entry_t'(d[g*E +: E]));
            rr = (g + 1) % NUM_CH;
         end
      end
      @(posedge clk);
   endtask

   initial begin
      logic [NUM_CH*E-1:0] d;
      logic r, fl, rdy;
      last = '0;

      cyc(1, 0, 0, '0, '0);
      cyc(1, 0, 0, '0, '0);
      cyc(0, 0, 0, '0, '0);
      chk("rst_cnt", cap_cnt, 0);
      chk("rst_pc",  cap_pc, 0);

      // single push, visible next cycle, then popped
      cyc(0, 0, 1, 2'b01, {mk(0, 0, 0), mk(1, 3'd5, 32'h0000_1000)});
      chk("single_rdy", 64'(cap_ready), 1);
      cyc(0, 0, 1, '0, '0);
      chk("single_vld", cap_vld, 1);
      chk("single_pc",  cap_pc, 64'h1000);
      chk("single_idx", cap_idx, 5);
      chk("single_typ", cap_typ, 1);
      cyc(0, 0, 1, '0, '0);
      chk("single_cnt0", cap_cnt, 0);
      chk("single_hold", cap_pc, 64'h1000);

      // flush to restart arbitration at ch0, then fill with both channels requesting
      cyc(0, 1, 0, '0, '0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 2'b11, rnd_data());
         chk("alt_grant", 64'(cap_ready), (i % 2) ? 2 : 1);
      end
      cyc(0, 0, 0, 2'b11, rnd_data());
      chk("full_cnt", cap_cnt, 4);
      chk("full_rdy", 64'(cap_ready), 0);

      // full with concurrent pop: ch1 keeps pushing, occupancy holds across wrap
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 1, 2'b10, rnd_data());
         chk("full_pp_cnt", cap_cnt, 4);
         chk("full_pp_rdy", 64'(cap_ready), 2);
      end

      // move rr to ch1, drop to 3, then flush with ch0 requesting
      cyc(0, 0, 1, 2'b01, rnd_data());
      cyc(0, 0, 1, 2'b00, '0);
      cyc(0, 1, 0, 2'b01, rnd_data());
      chk("flush_cnt3", cap_cnt, 3);
      chk("flush_rdy",  64'(cap_ready), 0);
      cyc(0, 0, 0, 2'b11, rnd_data());
      chk("post_flush_cnt", cap_cnt, 0);
      chk("post_flush_vld", cap_vld, 0);
      chk("post_flush_gnt", 64'(cap_ready), 1);

      // reset with two entries queued
      cyc(0, 0, 0, 2'b11, rnd_data());
      cyc(1, 0, 0, 2'b11, rnd_data());
      chk("pre_rst_cnt", cap_cnt, 2);
      d = {mk(0, 0, 0), mk(0, 3'd2, 32'hCAFE_0040)};
      cyc(0, 0, 0, 2'b01, d);
      chk("post_rst_cnt", cap_cnt, 0);
      chk("post_rst_pc",  cap_pc, 0);
      chk("post_rst_idx", cap_idx, 0);
      chk("post_rst_typ", cap_typ, 0);
      cyc(0, 0, 0, '0, '0);
      chk("post_rst_push", cap_pc, 64'hCAFE_0040);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(0, 79) == 0);
         fl  = ($urandom_range(0, 19) == 0);
         rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cyc(r, fl, rdy, NUM_CH'($urandom()), rnd_data());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
